// File: rtl/mips_cpu_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_mem_bridge
// Brief    : Turns the multicycle CPU's memread/memwrite strobes into one
//            Avalon-MM master transaction with ack, error and timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mips_cpu_mem_bridge #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_writedata,
    output logic [31:0] cpu_readdata,
    output logic        cpu_ack,
    output logic        cpu_err,
    output logic        cpu_busy,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic             C_TO_EN    = (TIMEOUT != 0);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [3:0]        be_q, be_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    logic w_req_one;
    logic w_req_any;
    logic w_aligned;

    assign w_req_one = cpu_read ^ cpu_write;
    assign w_req_any = cpu_read | cpu_write;
    assign w_aligned = (cpu_addr[1:0] == 2'b00);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_req_one && w_aligned) begin
                    addr_d  = {cpu_addr[31:2], 2'b00};
                    wdata_d = cpu_writedata;
                    rd_d    = cpu_read;
                    wr_d    = cpu_write;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end else if (w_req_any) begin
                    // Misaligned or read+write together: reject without touching the bus.
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_BUSY: begin
                if (!avm_waitrequest) begin
                    if (rd_q) begin
                        rdata_d = avm_readdata;
                    end
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    ack_d   = 1'b1;
                    state_d = S_RESP;
                end else if (C_TO_EN && (cnt_q == C_CNT_LAST)) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        be_d   = (rd_d | wr_d) ? 4'b1111 : 4'b0000;
        busy_d = (state_d != S_IDLE);
    end

    // Async reset drops the bus strobes immediately; the aborted access gets no ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            be_q    <= 4'b0000;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            be_q    <= be_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign cpu_readdata   = rdata_q;
    assign cpu_ack        = ack_q;
    assign cpu_err        = err_q;
    assign cpu_busy       = busy_q;
    assign avm_address    = addr_q;
    assign avm_read       = rd_q;
    assign avm_write      = wr_q;
    assign avm_writedata  = wdata_q;
    assign avm_byteenable = be_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_cpu_mem_bridge
// Brief    : Directed plus randomized bench for mips_cpu_mem_bridge with a
//            cycle-schedule reference model of each transaction.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_cpu_mem_bridge;

    localparam int C_TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_read, cpu_write;
    logic [31:0] cpu_addr, cpu_writedata, cpu_readdata;
    logic        cpu_ack, cpu_err, cpu_busy;
    logic [31:0] avm_address, avm_writedata, avm_readdata;
    logic        avm_read, avm_write, avm_waitrequest;
    logic [3:0]  avm_byteenable;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] exp_rdata;

    mips_cpu_mem_bridge #(.TIMEOUT(C_TO), .CNT_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_read       (cpu_read),
        .cpu_write      (cpu_write),
        .cpu_addr       (cpu_addr),
        .cpu_writedata  (cpu_writedata),
        .cpu_readdata   (cpu_readdata),
        .cpu_ack        (cpu_ack),
        .cpu_err        (cpu_err),
        .cpu_busy       (cpu_busy),
        .avm_address    (avm_address),
        .avm_read       (avm_read),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_byteenable (avm_byteenable),
        .avm_readdata   (avm_readdata),
        .avm_waitrequest(avm_waitrequest)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One CPU access. 'waits' is how many cycles the slave stalls before answering;
    // a stall of C_TO or more cycles must end in a timeout after C_TO strobe cycles.
    task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdv, input int waits);
        logic        bad, to;
        int          n;
        logic [31:0] wa;
        bad = (rd & wr) | (addr[1:0] != 2'b00);
        wa  = {addr[31:2], 2'b00};
        to  = 1'b0;
        check("idle_busy", cpu_busy, 0);
        cpu_read        = rd;
        cpu_write       = wr;
        cpu_addr        = addr;
        cpu_writedata   = wdata;
        avm_waitrequest = 1'b1;
        step();
        if (!bad) begin
            to = (waits >= C_TO);
            n  = to ? C_TO : waits + 1;
            for (int k = 0; k < n; k++) begin
                check("strobe_rd",   avm_read, rd);
                check("strobe_wr",   avm_write, wr);
                check("strobe_addr", avm_address, wa);
                check("strobe_data", avm_writedata, wdata);
                check("strobe_be",   avm_byteenable, 4'hF);
                check("strobe_ack",  cpu_ack, 0);
                check("strobe_busy", cpu_busy, 1);
                avm_waitrequest = (k < waits);
                avm_readdata    = (k == waits) ? rdv : $urandom;
                cpu_addr        = $urandom;
                cpu_writedata   = $urandom;
                step();
            end
            if (rd && !to) exp_rdata = rdv;
        end
        check("ack",      cpu_ack, 1);
        check("ack_err",  cpu_err, {31'd0, bad | to});
        check("ack_rd",   avm_read, 0);
        check("ack_wr",   avm_write, 0);
        check("ack_be",   avm_byteenable, 4'h0);
        check("ack_data", cpu_readdata, exp_rdata);
        check("ack_busy", cpu_busy, 1);
        avm_waitrequest = 1'b1;
        step();
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        check("post_ack",  cpu_ack, 0);
        check("post_err",  cpu_err, 0);
        check("post_busy", cpu_busy, 0);
        check("post_rd",   avm_read, 0);
        check("post_data", cpu_readdata, exp_rdata);
    endtask

    initial begin
        int mode, waits;
        logic [31:0] a;
        reset           = 1'b1;
        cpu_read        = 1'b0;
        cpu_write       = 1'b0;
        cpu_addr        = '0;
        cpu_writedata   = '0;
        avm_readdata    = '0;
        avm_waitrequest = 1'b1;
        exp_rdata       = '0;
        #3;
        check("rst_rdata", cpu_readdata, 0);
        check("rst_ack",   cpu_ack, 0);
        check("rst_err",   cpu_err, 0);
        check("rst_busy",  cpu_busy, 0);
        check("rst_addr",  avm_address, 0);
        check("rst_wdata", avm_writedata, 0);
        check("rst_strb",  {30'd0, avm_read, avm_write}, 0);
        check("rst_be",    avm_byteenable, 0);
        step();
        step();
        reset = 1'b0;
        step();

        // Directed scenarios.
        txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0);
        txn(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0, 3);
        txn(1'b1, 1'b0, 32'h0000_0006, 32'h0, 32'h5555_AAAA, 0);
        txn(1'b1, 1'b1, 32'h0000_0030, 32'h0, 32'h5555_AAAA, 0);
        txn(1'b1, 1'b0, 32'h0000_0044, 32'h0, 32'hBAD0_BAD0, 100);

        // Reset while a read is stalled on the bus.
        cpu_read        = 1'b1;
        cpu_addr        = 32'h0000_0040;
        avm_waitrequest = 1'b1;
        step();
        step();
        check("pre_rst_rd", avm_read, 1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_rd",   avm_read, 0);
        check("mid_rst_busy", cpu_busy, 0);
        check("mid_rst_ack",  cpu_ack, 0);
        check("mid_rst_be",   avm_byteenable, 0);
        cpu_read  = 1'b0;
        exp_rdata = '0;
        step();
        reset = 1'b0;
        step();
        check("post_rst_data", cpu_readdata, 0);
        txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 1);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            mode  = $urandom_range(0, 9);
            waits = $urandom_range(0, 5);
            a     = $urandom;
            if (mode == 0) begin
                txn(1'b1, 1'b1, {a[31:2], 2'b00}, $urandom, $urandom, waits);
            end else if (mode == 1) begin
                a[1:0] = 2'($urandom_range(1, 3));
                txn(a[2], ~a[2], a, $urandom, $urandom, waits);
            end else begin
                txn(mode[0], ~mode[0], {a[31:2], 2'b00}, $urandom, $urandom, waits);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
